uop_issue_stage: RTL and testbench
==================================

Name: uop_issue_stage

Overview:
- Consumer end of the decoded-uop interface. Accepts `uop_t` micro-ops from decode over a valid/ready handshake.
- Buffers one uop, checks RAW/WAW hazards against a 32-entry register scoreboard, and issues in order to the execute stage through a registered valid/ready output.
- Writeback clears scoreboard entries. Flush discards buffered and not-yet-accepted uops.

Parameters:
- NREGS, 32, number of architectural integer registers (scoreboard width)
- STALL_CNT_W, 16, width of saturating hazard-stall counter

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  decode presents a uop
- in_uop  input  69  `riscv_uop_pkg::uop_t` from decode
- in_ready  output  1  stage can accept a uop this cycle
- iss_valid  output  1  registered uop available to execute
- iss_uop  output  69  registered `uop_t` to execute
- iss_ready  input  1  execute accepts `iss_uop`
- wb_valid  input  1  writeback of a register result
- wb_rd  input  5  writeback destination register
- flush  input  1  discard all uops not yet accepted by execute
- illegal  output  1  one-cycle pulse, accepted uop had `uop.valid=0`
- scoreboard  output  NREGS  pending-write bit per register (bit 0 always 0)
- stall_cnt  output  STALL_CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (async assert, sync deassert use) drives the following to 0: `in_ready`, `hold_valid`, `iss_valid`, `iss_uop`, `scoreboard`, `stall_cnt`, `illegal`. `in_ready` may go 1 from the first cycle after `rst_n` rises.
- Internal holding register `hold` (1 entry) feeds the output register (`iss_valid`/`iss_uop`, 1 entry).
- Accept: `in_valid && in_ready` captures `in_uop` into `hold`.
  - If `in_uop.valid == 0`, the uop is consumed but not stored.
  - `illegal` = 1 in the next cycle.
- `in_ready = !hold_valid || move`, where `move` = hold transfers to the output register this cycle. Combinational in state; not a function of `in_valid`.
- Pending mask:
  - `P = scoreboard & ~WB | OUT`.
  - `WB` = one-hot(`wb_rd`) when `wb_valid` (writeback bypass, same cycle).
  - `OUT` = one-hot(`iss_uop.rd`) when `iss_valid && iss_uop.writes_rd`.
  - Bit 0 of `P` is forced to 0.
- Hazard (on `hold`): `(uses_rs1 && P[rs1]) || (uses_rs2 && P[rs2]) || (writes_rd && P[rd])`.
- Move: `hold_valid && !hazard && (!iss_valid || iss_ready)`. On move, the output register loads `hold` and `iss_valid=1`.
- Output: `iss_valid` stays 1 and `iss_uop` is stable until `iss_ready`.
  - If `iss_valid && iss_ready` with no move, `iss_valid` goes to 0.
  - Minimum latency from accept to `iss_valid`: 2 cycles.
  - Back-to-back independent uops sustain 1/cycle.
- Scoreboard:
  - Set: bit `rd` on `iss_valid && iss_ready && iss_uop.writes_rd && rd != 0`.
  - Clear: bit `wb_rd` on `wb_valid`.
  - Same register set and cleared in the same cycle: set wins.
  - `wb_valid` for a register with bit already 0 is a no-op. `wb_rd=0` is ignored.
- Stall counter: increments when `hold_valid && hazard`, saturates at all-ones. Back-pressure alone (`iss_valid && !iss_ready`, no hazard) does not count.
- Flush (synchronous, highest priority):
  - Next cycle: `hold_valid=0` and `iss_valid=0`.
  - No accept or move in the flush cycle; `in_ready=0` during the flush cycle.
  - Scoreboard bits are kept, because already-issued uops still write back.
  - A handshake `iss_valid && iss_ready` in the flush cycle completes normally, and its scoreboard set applies.
  - `illegal` is not pulsed for a flush-cycle uop.
- Async reset mid-operation: all state is cleared immediately; any in-flight scoreboard information is lost by design.

Test Plan:
- Independent stream: 4 uops `addi x1..x4, x0, k` with `in_valid=1`, `iss_ready=1`.
  - `iss_valid` at cycle 2 after the first accept, then 1 uop/cycle in order.
  - `scoreboard` = `0x1E` after all four issue.
- RAW stall: issue `add x5`; hold `add x6, x5, x5`; no writeback for 3 cycles, then `wb_valid`, `wb_rd=5`.
  - x6 uop moves in the `wb_valid` cycle (bypass).
  - `stall_cnt=3`, `in_ready=0` while stalled.
- Back-pressure: `iss_ready=0` for 5 cycles with 3 uops offered.
  - `iss_uop` stable, `hold` full, `in_ready=0` after 2 accepts, `stall_cnt` unchanged.
  - Drains in order when `iss_ready` returns to 1.
- x0 / illegal:
  - `writes_rd` with `rd=0` never sets `scoreboard[0]`.
  - Uop with `valid=0` gives `illegal=1` for one cycle and `iss_valid` stays 0.
- Flush: `hold` and output both full, `flush=1` with `iss_ready=0`.
  - Next cycle `iss_valid=0`, `hold` empty, `scoreboard` unchanged.
  - A later `wb_valid` clears the outstanding bit.
- Reset mid-stall: assert `rst_n=0` while `hold` is stalled with `scoreboard=0x20`.
  - All outputs 0 immediately.
  - After release, the first new uop issues with no stall.

Source files
------------

// File: rtl/uop_issue_stage.sv
// Decoded-uop issue stage: one-entry hold buffer, register scoreboard hazard check,
// and a registered valid/ready output toward execute.

package riscv_uop_pkg;

  typedef struct packed {
    logic        valid;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        writes_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [5:0]  alu_op;
    logic [3:0]  fu_sel;
    logic [7:0]  tag;
    logic [31:0] imm;
  } uop_t;

endpackage

module uop_issue_stage
  import riscv_uop_pkg::*;
#(
  parameter int NREGS       = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  uop_t                   in_uop,
  output logic                   in_ready,
  output logic                   iss_valid,
  output uop_t                   iss_uop,
  input  logic                   iss_ready,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_rd,
  input  logic                   flush,
  output logic                   illegal,
  output logic [NREGS-1:0]       scoreboard,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic                   rdy_en_q;
  logic                   hold_valid_q;
  uop_t                   hold_q;
  logic                   iss_valid_q;
  uop_t                   iss_uop_q;
  logic [NREGS-1:0]       sb_q;
  logic [NREGS-1:0]       sb_d;
  logic [STALL_CNT_W-1:0] stall_q;
  logic [STALL_CNT_W-1:0] stall_d;
  logic                   illegal_q;

  logic [NREGS-1:0] wb_mask;
  logic [NREGS-1:0] out_mask;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] pend;
  logic             hazard;
  logic             move;
  logic             accept;
  logic             iss_fire;
  logic             in_ready_c;

  always_comb begin
    wb_mask = '0;
    if (wb_valid) wb_mask[wb_rd] = 1'b1;

    // The uop sitting in the output register counts as pending even before it fires.
    out_mask = '0;
    if (iss_valid_q && iss_uop_q.writes_rd) out_mask[iss_uop_q.rd] = 1'b1;

    pend    = (sb_q & ~wb_mask) | out_mask;
    pend[0] = 1'b0;

    hazard = (hold_q.uses_rs1  && pend[hold_q.rs1]) ||
             (hold_q.uses_rs2  && pend[hold_q.rs2]) ||
             (hold_q.writes_rd && pend[hold_q.rd]);

    move       = !flush && hold_valid_q && !hazard && (!iss_valid_q || iss_ready);
    in_ready_c = rdy_en_q && !flush && (!hold_valid_q || move);
    accept     = in_valid && in_ready_c;
    iss_fire   = iss_valid_q && iss_ready;

    set_mask = '0;
    if (iss_fire && iss_uop_q.writes_rd) set_mask[iss_uop_q.rd] = 1'b1;

    sb_d    = (sb_q & ~wb_mask) | set_mask;
    sb_d[0] = 1'b0;

    stall_d = stall_q;
    if (hold_valid_q && hazard && (stall_q != '1)) stall_d = stall_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q     <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
      iss_valid_q  <= 1'b0;
      iss_uop_q    <= '0;
      sb_q         <= '0;
      stall_q      <= '0;
      illegal_q    <= 1'b0;
    end else begin
      rdy_en_q  <= 1'b1;
      sb_q      <= sb_d;
      stall_q   <= stall_d;
      illegal_q <= accept && !in_uop.valid;

      if (flush) begin
        hold_valid_q <= 1'b0;
      end else if (accept && in_uop.valid) begin
        hold_valid_q <= 1'b1;
        hold_q       <= in_uop;
      end else if (move) begin
        hold_valid_q <= 1'b0;
      end

      if (flush) begin
        iss_valid_q <= 1'b0;
      end else if (move) begin
        iss_valid_q <= 1'b1;
        iss_uop_q   <= hold_q;
      end else if (iss_ready) begin
        iss_valid_q <= 1'b0;
      end
    end
  end

  assign in_ready   = in_ready_c;
  assign iss_valid  = iss_valid_q;
  assign iss_uop    = iss_uop_q;
  assign illegal    = illegal_q;
  assign scoreboard = sb_q;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_uop_issue_stage.sv
// Directed bench for uop_issue_stage: each step drives inputs just after a rising
// edge and checks hand-computed expectations with immediate assertions.

module tb_uop_issue_stage;
  import riscv_uop_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  uop_t        in_uop;
  logic        in_ready;
  logic        iss_valid;
  uop_t        iss_uop;
  logic        iss_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic        illegal;
  logic [31:0] scoreboard;
  logic [15:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  uop_issue_stage #(.NREGS(32), .STALL_CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_uop     (in_uop),
    .in_ready   (in_ready),
    .iss_valid  (iss_valid),
    .iss_uop    (iss_uop),
    .iss_ready  (iss_ready),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .flush      (flush),
    .illegal    (illegal),
    .scoreboard (scoreboard),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic uop_t mk(input logic v, input logic u1, input logic u2, input logic w,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [7:0] tag);
    uop_t u;
    u           = '0;
    u.valid     = v;
    u.uses_rs1  = u1;
    u.uses_rs2  = u2;
    u.writes_rd = w;
    u.rs1       = rs1;
    u.rs2       = rs2;
    u.rd        = rd;
    u.tag       = tag;
    u.imm       = {24'h0, tag};
    return u;
  endfunction

  task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_uop = '0; iss_ready = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_iss_valid", iss_valid, 1'b0);
    chk("rst_iss_uop", iss_uop, '0);
    chk("rst_scoreboard", scoreboard, 32'h0);
    chk("rst_stall_cnt", stall_cnt, 16'h0);
    chk("rst_illegal", illegal, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    step;
    chk("rst_rdy_after", in_ready, 1'b1);

    // Independent stream addi x1..x4
    iss_ready = 1'b1; in_valid = 1'b1; in_uop = mk(1, 1, 0, 1, 0, 0, 1, 8'h01);
    step;
    chk("t1_lat1_valid", iss_valid, 1'b0);
    in_uop = mk(1, 1, 0, 1, 0, 0, 2, 8'h02);
    step;
    chk("t1_lat2_valid", iss_valid, 1'b1);
    chk("t1_uop1", iss_uop, mk(1, 1, 0, 1, 0, 0, 1, 8'h01));
    in_uop = mk(1, 1, 0, 1, 0, 0, 3, 8'h03);
    step;
    chk("t1_uop2", iss_uop, mk(1, 1, 0, 1, 0, 0, 2, 8'h02));
    in_uop = mk(1, 1, 0, 1, 0, 0, 4, 8'h04);
    step;
    chk("t1_uop3", iss_uop, mk(1, 1, 0, 1, 0, 0, 3, 8'h03));
    in_valid = 1'b0;
    step;
    chk("t1_uop4", iss_uop, mk(1, 1, 0, 1, 0, 0, 4, 8'h04));
    step;
    chk("t1_drained", iss_valid, 1'b0);
    chk("t1_scoreboard", scoreboard, 32'h1E);
    chk("t1_stall", stall_cnt, 16'd0);
    for (int r = 1; r <= 4; r++) begin
      wb_valid = 1'b1; wb_rd = 5'(r);
      step;
    end
    wb_valid = 1'b0;
    chk("t1_sb_cleared", scoreboard, 32'h0);

    // RAW stall: add x5; add x6,x5,x5
    in_valid = 1'b1; in_uop = mk(1, 1, 1, 1, 0, 0, 5, 8'h05);
    step;
    in_uop = mk(1, 1, 1, 1, 5, 5, 6, 8'h06);
    step;
    in_valid = 1'b0;
    #1;
    chk("t2_rdy_stall0", in_ready, 1'b0);
    step;
    chk("t2_sb_x5", scoreboard, 32'h20);
    chk("t2_rdy_stall1", in_ready, 1'b0);
    step;
    step;
    chk("t2_iss_idle", iss_valid, 1'b0);
    wb_valid = 1'b1; wb_rd = 5'd5;
    #1;
    chk("t2_rdy_bypass", in_ready, 1'b1);
    chk("t2_stall3", stall_cnt, 16'd3);
    step;
    wb_valid = 1'b0;
    chk("t2_iss_x6", iss_uop, mk(1, 1, 1, 1, 5, 5, 6, 8'h06));
    chk("t2_iss_valid", iss_valid, 1'b1);
    chk("t2_sb_clr", scoreboard, 32'h0);
    chk("t2_stall_hold", stall_cnt, 16'd3);
    step;
    chk("t2_sb_x6", scoreboard, 32'h40);
    wb_valid = 1'b1; wb_rd = 5'd6;
    step;
    wb_valid = 1'b0;

    // Back-pressure: iss_ready low for 5 cycles, 3 uops offered
    iss_ready = 1'b0; in_valid = 1'b1; in_uop = mk(1, 1, 0, 1, 0, 0, 7, 8'h07);
    step;
    in_uop = mk(1, 1, 0, 1, 0, 0, 8, 8'h08);
    step;
    in_uop = mk(1, 1, 0, 1, 0, 0, 9, 8'h09);
    #1;
    chk("t3_rdy_full", in_ready, 1'b0);
    step;
    step;
    step;
    chk("t3_iss_stable", iss_uop, mk(1, 1, 0, 1, 0, 0, 7, 8'h07));
    chk("t3_iss_valid", iss_valid, 1'b1);
    chk("t3_rdy_full2", in_ready, 1'b0);
    chk("t3_stall_same", stall_cnt, 16'd3);
    iss_ready = 1'b1;
    #1;
    chk("t3_rdy_resume", in_ready, 1'b1);
    step;
    in_valid = 1'b0;
    chk("t3_drain_x8", iss_uop, mk(1, 1, 0, 1, 0, 0, 8, 8'h08));
    step;
    chk("t3_drain_x9", iss_uop, mk(1, 1, 0, 1, 0, 0, 9, 8'h09));
    step;
    chk("t3_drained", iss_valid, 1'b0);
    chk("t3_scoreboard", scoreboard, 32'h380);
    chk("t3_stall_end", stall_cnt, 16'd3);
    for (int r = 7; r <= 9; r++) begin
      wb_valid = 1'b1; wb_rd = 5'(r);
      step;
    end
    wb_valid = 1'b0;

    // x0 destination, then illegal uop
    in_valid = 1'b1; in_uop = mk(1, 1, 0, 1, 0, 0, 0, 8'h10);
    step;
    in_valid = 1'b0;
    step;
    chk("t4_iss_x0", iss_uop, mk(1, 1, 0, 1, 0, 0, 0, 8'h10));
    step;
    chk("t4_sb_x0", scoreboard, 32'h0);
    in_valid = 1'b1; in_uop = mk(0, 1, 1, 1, 1, 2, 10, 8'h11);
    step;
    in_valid = 1'b0;
    #1;
    chk("t4_illegal_pulse", illegal, 1'b1);
    chk("t4_illegal_rdy", in_ready, 1'b1);
    chk("t4_illegal_noiss", iss_valid, 1'b0);
    step;
    chk("t4_illegal_end", illegal, 1'b0);
    chk("t4_illegal_noiss2", iss_valid, 1'b0);
    chk("t4_illegal_sb", scoreboard, 32'h0);

    // Flush with hold and output full
    in_valid = 1'b1; in_uop = mk(1, 1, 0, 1, 0, 0, 11, 8'h20);
    step;
    in_valid = 1'b0;
    step;
    step;
    chk("t5_sb_x11", scoreboard, 32'h800);
    iss_ready = 1'b0; in_valid = 1'b1; in_uop = mk(1, 1, 0, 1, 0, 0, 12, 8'h21);
    step;
    in_uop = mk(1, 1, 0, 1, 0, 0, 13, 8'h22);
    step;
    in_valid = 1'b0; flush = 1'b1;
    #1;
    chk("t5_flush_rdy", in_ready, 1'b0);
    chk("t5_pre_iss", iss_valid, 1'b1);
    step;
    flush = 1'b0;
    #1;
    chk("t5_post_iss", iss_valid, 1'b0);
    chk("t5_post_hold", in_ready, 1'b1);
    chk("t5_post_sb", scoreboard, 32'h800);
    chk("t5_post_illegal", illegal, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_uop = mk(1, 1, 0, 1, 0, 0, 12, 8'h23);
    #1;
    chk("t5_flush_rdy_empty", in_ready, 1'b0);
    step;
    flush = 1'b0; in_valid = 1'b0;
    step;
    chk("t5_no_accept", iss_valid, 1'b0);
    wb_valid = 1'b1; wb_rd = 5'd11;
    step;
    wb_valid = 1'b0;
    chk("t5_wb_clear", scoreboard, 32'h0);

    // Reset while stalled on x5
    iss_ready = 1'b1; in_valid = 1'b1; in_uop = mk(1, 1, 1, 1, 0, 0, 5, 8'h30);
    step;
    in_uop = mk(1, 1, 1, 1, 5, 5, 6, 8'h31);
    step;
    in_valid = 1'b0;
    step;
    step;
    chk("t6_pre_sb", scoreboard, 32'h20);
    chk("t6_pre_stall", stall_cnt, 16'd5);
    rst_n = 1'b0;
    #2;
    chk("t6_rst_in_ready", in_ready, 1'b0);
    chk("t6_rst_iss_valid", iss_valid, 1'b0);
    chk("t6_rst_iss_uop", iss_uop, '0);
    chk("t6_rst_sb", scoreboard, 32'h0);
    chk("t6_rst_stall", stall_cnt, 16'h0);
    chk("t6_rst_illegal", illegal, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    step;
    in_valid = 1'b1; in_uop = mk(1, 1, 1, 1, 5, 6, 7, 8'h32);
    #1;
    chk("t6_new_rdy", in_ready, 1'b1);
    step;
    in_valid = 1'b0;
    step;
    chk("t6_new_iss_valid", iss_valid, 1'b1);
    chk("t6_new_iss_uop", iss_uop, mk(1, 1, 1, 1, 5, 6, 7, 8'h32));
    chk("t6_new_stall", stall_cnt, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
